// File: rtl/riscv_tag_check_unit_pkg.sv
// Shared definitions for the tag check stage.
// Contents:
//   TAG_CAUSE_*      2-bit security exception cause codes, in priority order
//   TCR_*            bit positions of the Tag Check Register enables
//   tag_chk_state_e  exception handshake FSM states
//   tag_cause_encode priority encoder from per-check hit vector to cause code
package riscv_tag_check_unit_pkg;

    localparam logic [1:0] TAG_CAUSE_EXEC   = 2'd0;
    localparam logic [1:0] TAG_CAUSE_JUMP   = 2'd1;
    localparam logic [1:0] TAG_CAUSE_BRANCH = 2'd2;
    localparam logic [1:0] TAG_CAUSE_MEM    = 2'd3;

    localparam int TCR_EXEC   = 0;
    localparam int TCR_JUMP   = 1;
    localparam int TCR_BRANCH = 2;
    localparam int TCR_MEM    = 3;

    typedef enum logic [0:0] {
        TCHK_IDLE    = 1'b0,
        TCHK_PENDING = 1'b1
    } tag_chk_state_e;

    // Lowest hit index wins: exec > jump > branch > mem.
    function automatic logic [1:0] tag_cause_encode(input logic [3:0] hits);
        logic [1:0] cause;
        if (hits[TCR_EXEC]) begin
            cause = TAG_CAUSE_EXEC;
        end else if (hits[TCR_JUMP]) begin
            cause = TAG_CAUSE_JUMP;
        end else if (hits[TCR_BRANCH]) begin
            cause = TAG_CAUSE_BRANCH;
        end else begin
            cause = TAG_CAUSE_MEM;
        end
        return cause;
    endfunction

endpackage

// File: rtl/riscv_tag_check_unit_counter.sv
// Saturating violation counter with synchronous clear.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   inc         count one violation this cycle
//   clear       zero the counter (wins over inc)
//   count       current count, sticks at all-ones
module riscv_tag_viol_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Counter register: clear beats increment, increment stops at max.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/riscv_tag_check_unit.sv
// EX->WB tag stage: registers tag write-back, tracks the PC tag and checks
// each retiring instruction against the TCR policy. A violation squashes the
// tag write, raises a held exception request and stalls until acknowledged.
// Ports:
//   inputs : clk, rst_n, ex_valid_i, tag_result_i, rf_enable_tag_i,
//            pc_enable_tag_i, rf_we_ex_i, rf_waddr_ex_i, is_jump_i,
//            is_branch_i, is_mem_i, addr_tag_i, instr_tag_i, ex_pc_i, tcr_i,
//            exc_ack_i, cnt_clear_i
//   outputs: rf_tag_we_o, rf_tag_waddr_o, rf_tag_wdata_o, pc_tag_o,
//            exc_req_o, exc_cause_o, exc_pc_o, stall_o, viol_cnt_o
module riscv_tag_check_unit
    import riscv_tag_check_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 6,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    input  logic                  tag_result_i,
    input  logic                  rf_enable_tag_i,
    input  logic                  pc_enable_tag_i,
    input  logic                  rf_we_ex_i,
    input  logic [REG_ADDR_W-1:0] rf_waddr_ex_i,
    input  logic                  is_jump_i,
    input  logic                  is_branch_i,
    input  logic                  is_mem_i,
    input  logic                  addr_tag_i,
    input  logic                  instr_tag_i,
    input  logic [31:0]           ex_pc_i,
    input  logic [3:0]            tcr_i,
    input  logic                  exc_ack_i,
    input  logic                  cnt_clear_i,
    output logic                  rf_tag_we_o,
    output logic [REG_ADDR_W-1:0] rf_tag_waddr_o,
    output logic                  rf_tag_wdata_o,
    output logic                  pc_tag_o,
    output logic                  exc_req_o,
    output logic [1:0]            exc_cause_o,
    output logic [31:0]           exc_pc_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      viol_cnt_o
);

    tag_chk_state_e        state_r, state_next_s;
    logic [3:0]            hits_s;
    logic                  check_en_s;
    logic                  viol_s;
    logic                  wb_en_s;
    logic                  pc_upd_s;
    logic [1:0]            cause_s;

    logic                  rf_tag_we_r;
    logic [REG_ADDR_W-1:0] rf_tag_waddr_r;
    logic                  rf_tag_wdata_r;
    logic                  pc_tag_r;
    logic [1:0]            exc_cause_r;
    logic [31:0]           exc_pc_r;

    // Policy check and derived enables. Instructions retiring while a request
    // is pending are not checked at all, so the first violation is kept.
    always_comb begin
        hits_s             = 4'b0000;
        hits_s[TCR_EXEC]   = instr_tag_i & tcr_i[TCR_EXEC];
        hits_s[TCR_JUMP]   = is_jump_i & pc_enable_tag_i & tag_result_i & tcr_i[TCR_JUMP];
        hits_s[TCR_BRANCH] = is_branch_i & tag_result_i & tcr_i[TCR_BRANCH];
        hits_s[TCR_MEM]    = is_mem_i & addr_tag_i & tcr_i[TCR_MEM];
        check_en_s         = ex_valid_i & (state_r == TCHK_IDLE);
        viol_s             = check_en_s & (|hits_s);
        cause_s            = tag_cause_encode(hits_s);
        wb_en_s            = check_en_s & rf_we_ex_i & rf_enable_tag_i & ~viol_s;
        pc_upd_s           = check_en_s & is_jump_i & pc_enable_tag_i & ~viol_s;
    end

    // Exception handshake next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TCHK_IDLE: begin
                if (viol_s) begin
                    state_next_s = TCHK_PENDING;
                end else begin
                    state_next_s = TCHK_IDLE;
                end
            end
            TCHK_PENDING: begin
                if (exc_ack_i) begin
                    state_next_s = TCHK_IDLE;
                end else begin
                    state_next_s = TCHK_PENDING;
                end
            end
            default: begin
                state_next_s = TCHK_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= TCHK_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Tag write-back stage; address/data only move on an actual write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_tag_we_r    <= 1'b0;
            rf_tag_waddr_r <= {REG_ADDR_W{1'b0}};
            rf_tag_wdata_r <= 1'b0;
        end else if (wb_en_s) begin
            rf_tag_we_r    <= 1'b1;
            rf_tag_waddr_r <= rf_waddr_ex_i;
            rf_tag_wdata_r <= tag_result_i;
        end else begin
            rf_tag_we_r    <= 1'b0;
            rf_tag_waddr_r <= rf_tag_waddr_r;
            rf_tag_wdata_r <= rf_tag_wdata_r;
        end
    end

    // PC tag follows taken jumps that pass the check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_tag_r <= 1'b0;
        end else if (pc_upd_s) begin
            pc_tag_r <= tag_result_i;
        end else begin
            pc_tag_r <= pc_tag_r;
        end
    end

    // Cause and PC captured on the violating instruction, held until the next one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_cause_r <= TAG_CAUSE_EXEC;
            exc_pc_r    <= 32'h0000_0000;
        end else if (viol_s) begin
            exc_cause_r <= cause_s;
            exc_pc_r    <= ex_pc_i;
        end else begin
            exc_cause_r <= exc_cause_r;
            exc_pc_r    <= exc_pc_r;
        end
    end

    riscv_tag_viol_counter #(
        .CNT_W (CNT_W)
    ) u_viol_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (viol_s),
        .clear (cnt_clear_i),
        .count (viol_cnt_o)
    );

    assign rf_tag_we_o    = rf_tag_we_r;
    assign rf_tag_waddr_o = rf_tag_waddr_r;
    assign rf_tag_wdata_o = rf_tag_wdata_r;
    assign pc_tag_o       = pc_tag_r;
    assign exc_req_o      = (state_r == TCHK_PENDING);
    assign stall_o        = (state_r == TCHK_PENDING);
    assign exc_cause_o    = exc_cause_r;
    assign exc_pc_o       = exc_pc_r;

endmodule

// File: tb/tb_riscv_tag_check_unit.sv
// Table-driven bench for riscv_tag_check_unit. The counter is built narrow
// (4 bits) so saturation is reachable in a few dozen cycles.
module tb_riscv_tag_check_unit;

    localparam int AW = 6;
    localparam int CW = 4;

    typedef struct {
        logic          rst_n, ev, tag, rfen, pcen, rfwe;
        logic [AW-1:0] waddr;
        logic          jmp, br, mem, atag, itag;
        logic [31:0]   pc;
        logic [3:0]    tcr;
        logic          ack, clr;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic          e_wd, e_pct, e_req;
        logic [1:0]    e_cause;
        logic [31:0]   e_epc;
        logic [15:0]   e_cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n, ex_valid, tag_result, rf_en, pc_en, rf_we;
    logic [AW-1:0] rf_waddr;
    logic          is_jump, is_branch, is_mem, addr_tag, instr_tag;
    logic [31:0]   ex_pc;
    logic [3:0]    tcr;
    logic          exc_ack, cnt_clear;
    logic          rf_tag_we, rf_tag_wdata, pc_tag, exc_req, stall;
    logic [AW-1:0] rf_tag_waddr;
    logic [1:0]    exc_cause;
    logic [31:0]   exc_pc;
    logic [CW-1:0] viol_cnt;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    riscv_tag_check_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .tag_result_i(tag_result),
        .rf_enable_tag_i(rf_en), .pc_enable_tag_i(pc_en), .rf_we_ex_i(rf_we),
        .rf_waddr_ex_i(rf_waddr), .is_jump_i(is_jump), .is_branch_i(is_branch),
        .is_mem_i(is_mem), .addr_tag_i(addr_tag), .instr_tag_i(instr_tag),
        .ex_pc_i(ex_pc), .tcr_i(tcr), .exc_ack_i(exc_ack), .cnt_clear_i(cnt_clear),
        .rf_tag_we_o(rf_tag_we), .rf_tag_waddr_o(rf_tag_waddr),
        .rf_tag_wdata_o(rf_tag_wdata), .pc_tag_o(pc_tag), .exc_req_o(exc_req),
        .exc_cause_o(exc_cause), .exc_pc_o(exc_pc), .stall_o(stall),
        .viol_cnt_o(viol_cnt)
    );

    task automatic add(input logic r, ev, tg, rfe, pce, rwe, input logic [AW-1:0] wa,
                       input logic j, b, m, at, it, input logic [31:0] pc,
                       input logic [3:0] t, input logic ak, cl,
                       input logic ewe, input logic [AW-1:0] ewa, input logic ewd, epct, ereq,
                       input logic [1:0] ecause, input logic [31:0] eepc, input logic [15:0] ecnt);
        vec_t v;
        v.rst_n = r; v.ev = ev; v.tag = tg; v.rfen = rfe; v.pcen = pce; v.rfwe = rwe;
        v.waddr = wa; v.jmp = j; v.br = b; v.mem = m; v.atag = at; v.itag = it;
        v.pc = pc; v.tcr = t; v.ack = ak; v.clr = cl;
        v.e_we = ewe; v.e_wa = ewa; v.e_wd = ewd; v.e_pct = epct; v.e_req = ereq;
        v.e_cause = ecause; v.e_epc = eepc; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", idx, nm, act, exp);
        end
    endtask

    initial begin
        vec_t v, e;
        // rst ev tg rfe pce rwe wa  j b m at it pc          tcr     ak cl | we wa wd pct req cause epc       cnt
        add(0, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 0,0,   0, 0, 0, 0, 0, 2'd0, 32'h0,    0); // reset
        add(1, 1,1,1,0,1, 5,  0,0,0,0,0, 32'h10,     4'b0000, 0,0,   1, 5, 1, 0, 0, 2'd0, 32'h0,    0); // T1
        add(1, 1,1,0,0,1, 7,  0,0,0,0,0, 32'h14,     4'b0000, 0,0,   0, 0, 0, 0, 0, 2'd0, 32'h0,    0); // T2
        add(1, 1,1,1,1,1, 1,  1,0,0,0,0, 32'h18,     4'b0000, 0,0,   1, 1, 1, 1, 0, 2'd0, 32'h0,    0); // jump sets pc tag
        add(1, 1,0,0,1,0, 0,  1,0,0,0,0, 32'h1c,     4'b0000, 0,0,   0, 0, 0, 0, 0, 2'd0, 32'h0,    0); // jump clears pc tag
        add(1, 1,1,1,1,1, 1,  1,0,0,0,0, 32'h80,     4'b0010, 0,0,   0, 0, 0, 0, 1, 2'd1, 32'h80,   1); // T3 jump viol
        add(1, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 0,0,   0, 0, 0, 0, 1, 2'd1, 32'h80,   1);
        add(1, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 0,0,   0, 0, 0, 0, 1, 2'd1, 32'h80,   1);
        add(1, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 1,1,   0, 0, 0, 0, 0, 2'd1, 32'h80,   0); // ack + clear
        add(1, 1,1,1,0,1, 3,  0,0,1,1,1, 32'h100,    4'b1001, 0,0,   0, 0, 0, 0, 1, 2'd0, 32'h100,  1); // T4 exec beats mem
        add(1, 1,1,1,1,1, 4,  1,0,0,0,0, 32'h200,    4'b0010, 0,0,   0, 0, 0, 0, 1, 2'd0, 32'h100,  1); // ignored in pending
        add(1, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 1,0,   0, 0, 0, 0, 0, 2'd0, 32'h100,  1);
        add(1, 1,1,1,0,1, 9,  0,0,1,1,0, 32'h300,    4'b0111, 0,0,   1, 9, 1, 0, 0, 2'd0, 32'h100,  1); // T6 load, tcr[3]=0
        add(1, 1,1,0,1,0, 0,  1,0,0,0,0, 32'h304,    4'b0000, 0,0,   0, 0, 0, 1, 0, 2'd0, 32'h100,  1);
        add(1, 1,1,1,0,1, 2,  0,1,0,0,0, 32'h400,    4'b0100, 0,0,   0, 0, 0, 1, 1, 2'd2, 32'h400,  2); // branch viol
        add(1, 1,0,0,0,0, 0,  0,0,1,1,0, 32'h500,    4'b1000, 1,0,   0, 0, 0, 1, 0, 2'd2, 32'h400,  2); // ack, viol ignored
        add(1, 1,0,0,0,0, 0,  0,0,1,1,0, 32'h500,    4'b1000, 0,0,   0, 0, 0, 1, 1, 2'd3, 32'h500,  3); // mem viol
        add(0, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 0,0,   0, 0, 0, 0, 0, 2'd0, 32'h0,    0); // T6 reset in pending
        add(1, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 1,0,   0, 0, 0, 0, 0, 2'd0, 32'h0,    0); // ack while idle
        add(1, 0,1,1,1,1, 8,  1,1,1,1,1, 32'h600,    4'b1111, 0,0,   0, 0, 0, 0, 0, 2'd0, 32'h0,    0); // not valid
        // T5: drive past saturation, then clear racing a violation.
        for (int i = 0; i < 20; i++) begin
            logic [15:0] c;
            logic [31:0] p;
            c = (i + 1 > 15) ? 16'd15 : 16'(i + 1);
            p = 32'h1000 + 32'(i * 4);
            add(1, 1,0,0,0,0, 0, 0,0,0,0,1, p,    4'b0001, 0,0,  0, 0, 0, 0, 1, 2'd0, p, c);
            add(1, 0,0,0,0,0, 0, 0,0,0,0,0, 32'h0, 4'b0000, 1,0,  0, 0, 0, 0, 0, 2'd0, p, c);
        end
        add(1, 1,0,0,0,0, 0,  0,0,0,0,1, 32'h2000,   4'b0001, 0,1,   0, 0, 0, 0, 1, 2'd0, 32'h2000, 0);
        add(1, 0,0,0,0,0, 0,  0,0,0,0,0, 32'h0,      4'b0000, 1,0,   0, 0, 0, 0, 0, 2'd0, 32'h2000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            rst_n = v.rst_n; ex_valid = v.ev; tag_result = v.tag; rf_en = v.rfen;
            pc_en = v.pcen; rf_we = v.rfwe; rf_waddr = v.waddr; is_jump = v.jmp;
            is_branch = v.br; is_mem = v.mem; addr_tag = v.atag; instr_tag = v.itag;
            ex_pc = v.pc; tcr = v.tcr; exc_ack = v.ack; cnt_clear = v.clr;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            check(i, "rf_tag_we", 32'(rf_tag_we), 32'(e.e_we));
            if (e.e_we) begin
                check(i, "rf_tag_waddr", 32'(rf_tag_waddr), 32'(e.e_wa));
                check(i, "rf_tag_wdata", 32'(rf_tag_wdata), 32'(e.e_wd));
            end
            check(i, "pc_tag", 32'(pc_tag), 32'(e.e_pct));
            check(i, "exc_req", 32'(exc_req), 32'(e.e_req));
            check(i, "stall", 32'(stall), 32'(e.e_req));
            check(i, "exc_cause", 32'(exc_cause), 32'(e.e_cause));
            check(i, "exc_pc", exc_pc, e.e_epc);
            check(i, "viol_cnt", 32'(viol_cnt), 32'(e.e_cnt));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
